two_bit_adder: RTL and testbench

Registered ripple-carry adder. Default width is 2 bits; the width is parameterisable. It adds operands A and B plus a carry-in and presents Sum and CarryOUT from output registers one clock later. It is the arithmetic leaf of the part-1 datapath and is exhaustively verifiable at the default width (32 input combinations).

---
 rtl/two_bit_adder_pkg.sv | 12 +
 rtl/full_adder.sv | 18 +
 rtl/two_bit_adder.sv | 75 +++++++
 tb/tb_two_bit_adder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/two_bit_adder_pkg.sv
// rtl/two_bit_adder_pkg.sv - shared constants and types for the registered ripple-carry adder
package two_bit_adder_pkg;

   // Default operand width and the widest width the adder is built for.
   localparam int ADDER_BITS_DEFAULT = 2;
   localparam int ADDER_BITS_MAX     = 16;

   // Result vector {carry, sum} sized for the widest legal build. A given
   // instance uses only the low BITS+1 bits of it.
   typedef logic [ADDER_BITS_MAX:0] adder_result_t;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit combinational full adder, one link of the ripple chain
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic half_sum;

   // Propagate term shared by the sum and the carry.
   assign half_sum = a ^ b;

   assign s    = half_sum ^ cin;
   assign cout = (a & b) | (cin & half_sum);

endmodule

// File: rtl/two_bit_adder.sv
// rtl/two_bit_adder.sv - registered ripple-carry adder; TWO_BIT_ADDER_OVF_EN adds a registered Overflow output
module two_bit_adder
   import two_bit_adder_pkg::*;
#(
   parameter int BITS = ADDER_BITS_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [BITS-1:0] A,
   input  logic [BITS-1:0] B,
   input  logic            CarryIN,
   output logic [BITS-1:0] Sum,
   output logic            CarryOUT
`ifdef TWO_BIT_ADDER_OVF_EN
   ,
   output logic            Overflow
`endif
);

   // carry[i] enters stage i; carry[BITS] leaves the top stage.
   logic [BITS:0]   carry;
   logic [BITS-1:0] sum_d;
   logic [BITS-1:0] sum_q;
   logic            carry_out_d;
   logic            carry_out_q;

   assign carry[0] = CarryIN;

   // Ripple chain: one full adder per operand bit, carry handed upward.
   for (genvar i = 0; i < BITS; i++) begin : g_stage
      full_adder u_fa (
         .a    (A[i]),
         .b    (B[i]),
         .cin  (carry[i]),
         .s    (sum_d[i]),
         .cout (carry[i+1])
      );
   end

   assign carry_out_d = carry[BITS];

   // Output registers: load every edge, reset wins over the new result.
   always_ff @(posedge clk) begin
      if (reset) begin
         sum_q       <= '0;
         carry_out_q <= 1'b0;
      end else begin
         sum_q       <= sum_d;
         carry_out_q <= carry_out_d;
      end
   end

   assign Sum      = sum_q;
   assign CarryOUT = carry_out_q;

`ifdef TWO_BIT_ADDER_OVF_EN
   logic overflow_d;
   logic overflow_q;

   // Signed overflow: carry into the sign bit differs from carry out of it.
   assign overflow_d = carry[BITS] ^ carry[BITS-1];

   // Overflow register shares the latency and reset of the sum.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_d;
      end
   end

   assign Overflow = overflow_q;
`endif

endmodule

// File: tb/tb_two_bit_adder.sv
// tb/tb_two_bit_adder.sv - self-checking bench for two_bit_adder at BITS=2 and BITS=4
module tb_two_bit_adder;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] a, b;
   logic       cin;
   logic [1:0] sum;
   logic       cout;
   logic [3:0] a4, b4;
   logic       cin4;
   logic [3:0] sum4;
   logic       cout4;
`ifdef TWO_BIT_ADDER_OVF_EN
   logic       ovf, ovf4;
`endif

   int checks = 0;
   int errors = 0;

   // Values applied at the most recent edge, for the reference model.
   int cur_a, cur_b, cur_c, cur_a4, cur_b4, cur_c4;

   always #5 clk = ~clk;

   two_bit_adder #(.BITS(2)) u_dut2 (
      .clk      (clk),
      .reset    (reset),
      .A        (a),
      .B        (b),
      .CarryIN  (cin),
      .Sum      (sum),
      .CarryOUT (cout)
`ifdef TWO_BIT_ADDER_OVF_EN
      ,
      .Overflow (ovf)
`endif
   );

   two_bit_adder #(.BITS(4)) u_dut4 (
      .clk      (clk),
      .reset    (reset),
      .A        (a4),
      .B        (b4),
      .CarryIN  (cin4),
      .Sum      (sum4),
      .CarryOUT (cout4)
`ifdef TWO_BIT_ADDER_OVF_EN
      ,
      .Overflow (ovf4)
`endif
   );

   typedef struct {
      int a;
      int b;
      int c;
      int s;
      int co;
   } vec_t;

   vec_t tbl[8];

   function automatic int m_sum(int bits, int x, int y, int c);
      return (x + y + c) % (1 << bits);
   endfunction

   function automatic int m_carry(int bits, int x, int y, int c);
      return ((x + y + c) >= (1 << bits)) ? 1 : 0;
   endfunction

   function automatic int to_signed(int bits, int v);
      return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
   endfunction

   function automatic int m_ovf(int bits, int x, int y, int c);
      int r;
      r = to_signed(bits, x) + to_signed(bits, y) + c;
      return (r > (1 << (bits - 1)) - 1 || r < -(1 << (bits - 1))) ? 1 : 0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step(input int ta, input int tb, input int tc,
                       input int ua, input int ub, input int uc);
      @(negedge clk);
      a    = 2'(ta);
      b    = 2'(tb);
      cin  = 1'(tc);
      a4   = 4'(ua);
      b4   = 4'(ub);
      cin4 = 1'(uc);
      @(posedge clk);
      cur_a = ta; cur_b = tb; cur_c = tc;
      cur_a4 = ua; cur_b4 = ub; cur_c4 = uc;
      #1;
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".sum2"},   32'(sum),   32'(m_sum(2, cur_a, cur_b, cur_c)));
      chk({tag, ".cout2"},  32'(cout),  32'(m_carry(2, cur_a, cur_b, cur_c)));
      chk({tag, ".sum4"},   32'(sum4),  32'(m_sum(4, cur_a4, cur_b4, cur_c4)));
      chk({tag, ".cout4"},  32'(cout4), 32'(m_carry(4, cur_a4, cur_b4, cur_c4)));
`ifdef TWO_BIT_ADDER_OVF_EN
      chk({tag, ".ovf2"},   32'(ovf),   32'(m_ovf(2, cur_a, cur_b, cur_c)));
      chk({tag, ".ovf4"},   32'(ovf4),  32'(m_ovf(4, cur_a4, cur_b4, cur_c4)));
`endif
   endtask

   task automatic check_zero(input string tag);
      chk({tag, ".sum2"},  32'(sum),   32'd0);
      chk({tag, ".cout2"}, 32'(cout),  32'd0);
      chk({tag, ".sum4"},  32'(sum4),  32'd0);
      chk({tag, ".cout4"}, 32'(cout4), 32'd0);
`ifdef TWO_BIT_ADDER_OVF_EN
      chk({tag, ".ovf2"},  32'(ovf),   32'd0);
      chk({tag, ".ovf4"},  32'(ovf4),  32'd0);
`endif
   endtask

   initial begin
      // Hand-derived vectors at BITS=2: {A, B, CarryIN, Sum, CarryOUT}.
      tbl[0] = '{2, 1, 0, 3, 0};
      tbl[1] = '{2, 2, 0, 0, 1};
      tbl[2] = '{0, 0, 1, 1, 0};
      tbl[3] = '{1, 2, 1, 0, 1};
      tbl[4] = '{3, 3, 1, 3, 1};
      tbl[5] = '{0, 0, 0, 0, 0};
      tbl[6] = '{1, 1, 0, 2, 0};
      tbl[7] = '{3, 3, 0, 2, 1};

      // Reset held for two edges with the max-case operands present.
      reset = 1'b1;
      a = 2'd3; b = 2'd3; cin = 1'b1;
      a4 = 4'd15; b4 = 4'd15; cin4 = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         check_zero("reset_hold");
      end

      // First edge after release shows the held operands.
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("release.sum2",  32'(sum),   32'd3);
      chk("release.cout2", 32'(cout),  32'd1);
      chk("release.sum4",  32'(sum4),  32'd15);
      chk("release.cout4", 32'(cout4), 32'd1);

      // Table vectors against hand-computed expectations.
      for (int i = 0; i < 8; i++) begin
         step(tbl[i].a, tbl[i].b, tbl[i].c, 0, 0, 0);
         chk($sformatf("tbl%0d.sum", i),  32'(sum),  32'(tbl[i].s));
         chk($sformatf("tbl%0d.cout", i), 32'(cout), 32'(tbl[i].co));
      end

`ifdef TWO_BIT_ADDER_OVF_EN
      step(1, 1, 0, 7, 1, 0);
      chk("ovf_a.sum2",  32'(sum),  32'd2);
      chk("ovf_a.ovf2",  32'(ovf),  32'd1);
      chk("ovf_a.ovf4",  32'(ovf4), 32'd1);
      step(3, 3, 0, 15, 15, 0);
      chk("ovf_b.sum2",  32'(sum),  32'd2);
      chk("ovf_b.cout2", 32'(cout), 32'd1);
      chk("ovf_b.ovf2",  32'(ovf),  32'd0);
`endif

      // Width scaling at BITS=4.
      step(0, 0, 0, 15, 1, 0);
      chk("w4a.sum4",  32'(sum4),  32'd0);
      chk("w4a.cout4", 32'(cout4), 32'd1);
      step(0, 0, 0, 7, 8, 1);
      chk("w4b.sum4",  32'(sum4),  32'd0);
      chk("w4b.cout4", 32'(cout4), 32'd1);

      // Exhaustive sweep at BITS=2 with a one-cycle reset in the middle.
      for (int c = 0; c < 2; c++) begin
         for (int i = 0; i < 16; i++) begin
            if (c == 1 && i == 8) begin
               @(negedge clk);
               reset = 1'b1;
               a = 2'd3; b = 2'd3; cin = 1'b1;
               @(posedge clk);
               #1;
               check_zero("mid_reset");
               @(negedge clk);
               reset = 1'b0;
            end
            step(i / 4, i % 4, c, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1));
            check_model($sformatf("sweep_c%0d_i%0d", c, i));
         end
      end

      // Randomized stimulus on both widths.
      for (int n = 0; n < 40; n++) begin
         step($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
              $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1));
         check_model($sformatf("rand%0d", n));
      end

      // Input changes between edges must not reach the outputs.
      step(2, 1, 0, 5, 6, 0);
      a = 2'd3; b = 2'd3; cin = 1'b1;
      a4 = 4'd15; b4 = 4'd15; cin4 = 1'b1;
      #2;
      check_model("between_edges");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
